// File: rtl/rgb_digit_if.sv
// Handshake and data bundle between a requester and rgb_digit_emitter:
// start/value in; busy, done, serial digit stream and parallel digits out.
interface rgb_digit_if;
    logic [7:0] value;
    logic       start;
    logic       busy;
    logic [4:0] digito;
    logic       cambio_digito;
    logic       done;
    logic [4:0] c_out;
    logic [4:0] d_out;
    logic [4:0] u_out;

    modport master (
        output value, start,
        input  busy, digito, cambio_digito, done, c_out, d_out, u_out
    );

    modport slave (
        input  value, start,
        output busy, digito, cambio_digito, done, c_out, d_out, u_out
    );
endinterface

// File: rtl/rgb_digit_emitter.sv
// Converts an 8-bit channel value to BCD by double dabble and replays it as a
// strobed digit stream. Define RGB_BLANK_LEADING_EN to blank leading zeros on c/d_out.
module rgb_digit_emitter #(
    parameter int GAP = 4
) (
    input  logic        clk,
    input  logic        reset,
    rgb_digit_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
    localparam logic [4:0] BLANK   = 5'd16;
    localparam logic [7:0] GAP_L   = GAP[7:0];

    logic [1:0]  state_reg;
    logic [7:0]  shift_reg;
    logic [11:0] bcd_reg;
    logic [2:0]  iter_reg;
    logic [1:0]  phase_reg;
    logic [7:0]  hold_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        cambio_reg;
    logic [4:0]  digito_reg;
    logic [4:0]  c_reg;
    logic [4:0]  d_reg;
    logic [4:0]  u_reg;

    logic [11:0] bcd_adj;
    logic [19:0] dd_shift;
    logic [11:0] bcd_next;
    logic [7:0]  shift_next;
    logic [4:0]  c_next;
    logic [4:0]  d_next;
    logic [4:0]  u_next;
    logic [1:0]  phase_sel;
    logic [4:0]  digit_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    assign dd_shift   = {bcd_adj, shift_reg} << 1;
    assign bcd_next   = dd_shift[19:8];
    assign shift_next = dd_shift[7:0];

    always_comb begin
        c_next = {1'b0, bcd_next[11:8]};
        d_next = {1'b0, bcd_next[7:4]};
        u_next = {1'b0, bcd_next[3:0]};
`ifdef RGB_BLANK_LEADING_EN
        if (bcd_next[11:8] == 4'd0) c_next = BLANK;
        if (bcd_next[11:4] == 8'd0) d_next = BLANK;
`else
        // parallel outputs carry plain 0-9 digits in this build
        c_next = {1'b0, bcd_next[11:8]};
`endif
    end

    // hold_reg==0 marks EMIT entry; otherwise a strobe advances to the next phase
    assign phase_sel = (hold_reg == 8'd0) ? phase_reg : phase_reg + 2'd1;

    always_comb begin
        case (phase_sel)
            2'd0:    digit_sel = {1'b0, bcd_reg[11:8]};
            2'd1:    digit_sel = {1'b0, bcd_reg[7:4]};
            default: digit_sel = {1'b0, bcd_reg[3:0]};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            shift_reg  <= 8'd0;
            bcd_reg    <= 12'd0;
            iter_reg   <= 3'd0;
            phase_reg  <= 2'd0;
            hold_reg   <= 8'd0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            cambio_reg <= 1'b0;
            digito_reg <= BLANK;
            c_reg      <= BLANK;
            d_reg      <= BLANK;
            u_reg      <= BLANK;
        end else begin
            cambio_reg <= 1'b0;
            done_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        shift_reg <= bus.value;
                        bcd_reg   <= 12'd0;
                        iter_reg  <= 3'd0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_CONV;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    shift_reg <= shift_next;
                    bcd_reg   <= bcd_next;
                    iter_reg  <= iter_reg + 3'd1;
                    if (iter_reg == 3'd7) begin
                        c_reg     <= c_next;
                        d_reg     <= d_next;
                        u_reg     <= u_next;
                        phase_reg <= 2'd0;
                        hold_reg  <= 8'd0;
                        state_reg <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (hold_reg == 8'd0) begin
                        digito_reg <= digit_sel;
                        cambio_reg <= 1'b1;
                        hold_reg   <= 8'd1;
                    end else if (hold_reg == GAP_L) begin
                        if (phase_reg == 2'd2) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_DONE;
                        end else begin
                            phase_reg  <= phase_sel;
                            digito_reg <= digit_sel;
                            cambio_reg <= 1'b1;
                            hold_reg   <= 8'd1;
                        end
                    end else begin
                        hold_reg <= hold_reg + 8'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_reg;
    assign bus.done          = done_reg;
    assign bus.cambio_digito = cambio_reg;
    assign bus.digito        = digito_reg;
    assign bus.c_out         = c_reg;
    assign bus.d_out         = d_reg;
    assign bus.u_out         = u_reg;
endmodule
